// File: rtl/dport_pxunpack_pkg.sv
// Shared DisplayPort pixel-path definitions: unpacker state encoding and beat geometry.
package dport_pxunpack_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StActive = 2'd1,
        StDone   = 2'd2
    } px_state_e;

    localparam int unsigned DpPixW  = 24;
    localparam int unsigned DpBeatW = 2 * DpPixW;

    function automatic logic [DpPixW-1:0] px_rgb(
        input logic              pix_bit,
        input logic [DpPixW-1:0] fg,
        input logic [DpPixW-1:0] bg
    );
        return pix_bit ? fg : bg;
    endfunction

endpackage

// File: rtl/dport_pxunpack.sv
// Expands 16-pixel monochrome Blit words into two-pixel RGB beats for the DP stuffer,
// trimming each line to the latched active width.
module dport_pxunpack
    import dport_pxunpack_pkg::*;
#(
    parameter logic [DpPixW-1:0] FGCOL = 24'h000000,
    parameter logic [DpPixW-1:0] BGCOL = 24'hFFFFFF
) (
    input  logic               dpclk,
    input  logic               reset_n,
    input  logic               dpdmahstart,
    input  logic [15:0]        hact,
    input  logic               raw_pixel_valid,
    input  logic [15:0]        raw_pixel_data,
    output logic               raw_pixel_ready,
    output logic               dp_pixel_valid,
    output logic [DpBeatW-1:0] dp_pixel_data,
    input  logic               dp_pixel_ready
);

    px_state_e          r_state;
    px_state_e          w_state_next;
    logic [15:0]        r_buf;
    logic               r_buf_full;
    logic [2:0]         r_pair;
    logic [15:0]        r_cnt;
    logic [15:0]        r_hact;
    logic               r_valid;
    logic [DpBeatW-1:0] r_data;

    logic               w_active;
    logic               w_out_free;
    logic [16:0]        w_cnt_next;
    logic               w_last;
    logic               w_right_pad;
    logic               w_take;
    logic               w_load;
    logic [15:0]        w_word;
    logic [2:0]         w_idx;
    logic               w_left;
    logic               w_right;

    always_comb begin
        w_active    = (r_state == StActive) && !dpdmahstart;
        w_out_free  = !r_valid || dp_pixel_ready;
        w_cnt_next  = {1'b0, r_cnt} + 17'd2;
        w_last      = w_cnt_next >= {1'b0, r_hact};
        w_right_pad = ({1'b0, r_cnt} + 17'd1) >= {1'b0, r_hact};
        // Refill on empty, or alongside the last pair so words stream without a bubble.
        raw_pixel_ready = w_active &&
                          (!r_buf_full || (w_out_free && (r_pair == 3'd7) && !w_last));
        w_take  = raw_pixel_valid && raw_pixel_ready;
        w_load  = w_active && w_out_free && (r_buf_full || raw_pixel_valid);
        // An empty buffer forwards the incoming word straight to the output register.
        w_word  = r_buf_full ? r_buf : raw_pixel_data;
        w_idx   = r_buf_full ? r_pair : 3'd0;
        w_left  = w_word[4'd15 - {w_idx, 1'b0}];
        w_right = w_word[4'd14 - {w_idx, 1'b0}] && !w_right_pad;
    end

    always_comb begin
        w_state_next = r_state;
        if (dpdmahstart) begin
            w_state_next = (hact == 16'd0) ? StDone : StActive;
        end else if (w_load && w_last) begin
            w_state_next = StDone;
        end
    end

    always_ff @(posedge dpclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= StIdle;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_pair     <= '0;
            r_cnt      <= '0;
            r_hact     <= '0;
            r_valid    <= 1'b0;
            r_data     <= '0;
        end else begin
            r_state <= w_state_next;
            if (dpdmahstart) begin
                r_buf_full <= 1'b0;
                r_pair     <= '0;
                r_cnt      <= '0;
                r_valid    <= 1'b0;
                r_hact     <= hact;
            end else begin
                if (w_load) begin
                    r_valid <= 1'b1;
                    r_data  <= {px_rgb(w_left, FGCOL, BGCOL), px_rgb(w_right, FGCOL, BGCOL)};
                    r_cnt   <= w_cnt_next[15:0];
                end else if (dp_pixel_ready) begin
                    r_valid <= 1'b0;
                end

                if (w_load && w_last) begin
                    r_buf_full <= 1'b0;
                end else if (w_take) begin
                    r_buf      <= raw_pixel_data;
                    r_buf_full <= 1'b1;
                    r_pair     <= (w_load && !r_buf_full) ? 3'd1 : 3'd0;
                end else if (w_load) begin
                    r_pair <= r_pair + 3'd1;
                    if (r_pair == 3'd7) begin
                        r_buf_full <= 1'b0;
                    end
                end
            end
        end
    end

    assign dp_pixel_valid = r_valid;
    assign dp_pixel_data  = r_data;

endmodule

// File: tb/tb_dport_pxunpack.sv
// Scoreboard bench for dport_pxunpack: a line-level pixel model fills an expected-beat queue,
// a negedge monitor drains it as beats are accepted.
module tb_dport_pxunpack;
    import dport_pxunpack_pkg::*;

    localparam logic [23:0] FG = 24'h000000;
    localparam logic [23:0] BG = 24'hFFFFFF;

    logic        dpclk;
    logic        reset_n;
    logic        dpdmahstart;
    logic [15:0] hact;
    logic        raw_pixel_valid;
    logic [15:0] raw_pixel_data;
    logic        raw_pixel_ready;
    logic        dp_pixel_valid;
    logic [47:0] dp_pixel_data;
    logic        dp_pixel_ready;

    dport_pxunpack #(
        .FGCOL(FG),
        .BGCOL(BG)
    ) dut (
        .dpclk          (dpclk),
        .reset_n        (reset_n),
        .dpdmahstart    (dpdmahstart),
        .hact           (hact),
        .raw_pixel_valid(raw_pixel_valid),
        .raw_pixel_data (raw_pixel_data),
        .raw_pixel_ready(raw_pixel_ready),
        .dp_pixel_valid (dp_pixel_valid),
        .dp_pixel_data  (dp_pixel_data),
        .dp_pixel_ready (dp_pixel_ready)
    );

    initial dpclk = 1'b0;
    always #5 dpclk = ~dpclk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [47:0] exp_q[$];
    logic [15:0] src_q[$];

    bit          src_en   = 1'b0;
    bit          src_rand = 1'b0;
    bit          rdy_rand = 1'b0;
    bit          first_pending = 1'b0;
    int          take_cyc   = -10;
    int          line_beats = 0;
    int          first_cyc  = 0;
    int          last_cyc   = 0;
    int          words_taken = 0;
    bit          prev_valid = 1'b0;
    bit          prev_ready = 1'b0;
    bit          prev_block = 1'b1;
    logic [47:0] prev_data  = '0;

    always @(posedge dpclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input int info);
        n_checks++;
        $display("FAIL %s: got event/value %0d, expected none", name, info);
    endtask

    function automatic logic [23:0] col(input bit b);
        return b ? FG : BG;
    endfunction

    // Pixel p of the line is bit (15 - p%16) of word p/16; odd widths pad with background.
    task automatic push_line(input int h);
        for (int p = 0; p < h; p += 2) begin
            logic [15:0] wl;
            logic [15:0] wr;
            bit          l;
            bit          r;
            wl = src_q[p / 16];
            l  = wl[15 - (p % 16)];
            r  = 1'b0;
            if (p + 1 < h) begin
                wr = src_q[(p + 1) / 16];
                r  = wr[15 - ((p + 1) % 16)];
            end
            exp_q.push_back({col(l), col(r)});
        end
    endtask

    task automatic step();
        @(posedge dpclk);
        #1;
        dpdmahstart     = 1'b0;
        raw_pixel_valid = src_en && (src_q.size() > 0) &&
                          (!src_rand || ($urandom_range(0, 3) != 0));
        raw_pixel_data  = (src_q.size() > 0) ? src_q[0] : 16'($urandom);
        dp_pixel_ready  = !rdy_rand || ($urandom_range(0, 2) != 0);
    endtask

    task automatic start_line(input int h);
        step();
        dpdmahstart = 1'b1;
        hact        = 16'(h);
        exp_q.delete();
        push_line(h);
        line_beats    = 0;
        take_cyc      = -10;
        first_pending = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            step();
            k++;
        end
        if (exp_q.size() != 0) begin
            fail_now("drain_timeout", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k = 0;
        while (line_beats < n && k < budget) begin
            step();
            k++;
        end
        if (line_beats < n) fail_now("beat_wait_timeout", line_beats);
    endtask

    task automatic fill_src(input int n);
        src_q.delete();
        for (int i = 0; i < n; i++) src_q.push_back(16'($urandom));
    endtask

    // Monitor: scoreboard pops, stall stability, first-beat latency, word consumption.
    initial begin
        logic [47:0] exp_beat;
        forever begin
            @(negedge dpclk);
            if (!reset_n) begin
                prev_block = 1'b1;
            end else begin
                if (!prev_block && prev_valid && !prev_ready) begin
                    check("stall_hold_valid", 64'(dp_pixel_valid), 64'd1);
                    check("stall_hold_data", 64'(dp_pixel_data), 64'(prev_data));
                end
                if (first_pending && dp_pixel_valid) begin
                    check("first_beat_latency", 64'(cyc), 64'(take_cyc + 1));
                    first_pending = 1'b0;
                end
                if (dp_pixel_valid && dp_pixel_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_beat", line_beats);
                    end else begin
                        exp_beat = exp_q.pop_front();
                        check("beat_data", 64'(dp_pixel_data), 64'(exp_beat));
                    end
                    if (line_beats == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    line_beats++;
                end
                if (raw_pixel_valid && raw_pixel_ready) begin
                    if (first_pending) take_cyc = cyc;
                    if (src_q.size() > 0) void'(src_q.pop_front());
                    words_taken++;
                end
                prev_valid = dp_pixel_valid;
                prev_ready = dp_pixel_ready;
                prev_data  = dp_pixel_data;
                prev_block = dpdmahstart;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int sz;
        int wt0;
        bit found;
        int k;

        reset_n         = 1'b0;
        dpdmahstart     = 1'b0;
        hact            = '0;
        raw_pixel_valid = 1'b0;
        raw_pixel_data  = '0;
        dp_pixel_ready  = 1'b0;
        #2;
        check("reset_dp_valid", 64'(dp_pixel_valid), 64'd0);
        check("reset_dp_data", 64'(dp_pixel_data), 64'd0);
        check("reset_raw_ready", 64'(raw_pixel_ready), 64'd0);

        // No activity after reset until a line start, even with data offered.
        repeat (3) step();
        reset_n = 1'b1;
        src_q.delete();
        src_q.push_back(16'h1357);
        src_en = 1'b1;
        repeat (6) step();
        #2;
        check("idle_raw_ready", 64'(raw_pixel_ready), 64'd0);
        check("idle_no_valid", 64'(dp_pixel_valid), 64'd0);
        check("idle_word_kept", 64'(src_q.size()), 64'd1);

        // A5A5 over a 16-pixel line, then DONE with the next word untouched.
        src_q.delete();
        src_q.push_back(16'hA5A5);
        src_q.push_back(16'h1234);
        start_line(16);
        wait_drain(60);
        repeat (3) step();
        #2;
        check("a5_beats", 64'(line_beats), 64'd8);
        check("a5_done_ready", 64'(raw_pixel_ready), 64'd0);
        check("a5_extra_kept", 64'(src_q.size()), 64'd1);

        // Full 1280-pixel line with both sides always ready.
        fill_src(81);
        wt0 = words_taken;
        start_line(1280);
        wait_drain(2000);
        repeat (3) step();
        check("wide_beats", 64'(line_beats), 64'd640);
        check("wide_no_bubble", 64'(last_cyc - first_cyc), 64'd639);
        check("wide_words", 64'(words_taken - wt0), 64'd80);

        // Random widths with random upstream gaps and downstream stalls.
        src_rand = 1'b1;
        rdy_rand = 1'b1;
        for (int ln = 0; ln < 8; ln++) begin
            int h;
            h = (ln == 0) ? 1 : int'($urandom_range(2, 200));
            fill_src((h + 15) / 16 + 1);
            start_line(h);
            wait_drain(4000);
            repeat (4) step();
            check("rand_line_beats", 64'(line_beats), 64'((h + 1) / 2));
            check("rand_extra_kept", 64'(src_q.size()), 64'd1);
        end
        src_rand = 1'b0;
        rdy_rand = 1'b0;

        // Odd width 3: last right pixel forced to background.
        src_q.delete();
        src_q.push_back(16'hFFFF);
        src_q.push_back(16'hFFFF);
        start_line(3);
        wait_drain(40);
        repeat (3) step();
        #2;
        check("h3_beats", 64'(line_beats), 64'd2);
        check("h3_ready_low", 64'(raw_pixel_ready), 64'd0);
        check("h3_extra_kept", 64'(src_q.size()), 64'd1);

        // Line start coinciding with a would-be word handshake at pair 7.
        fill_src(6);
        start_line(64);
        found = 1'b0;
        k = 0;
        while (!found && k < 40) begin
            step();
            #2;
            if (raw_pixel_valid && raw_pixel_ready) found = 1'b1;
            k++;
        end
        if (!found) fail_now("restart_first_take_timeout", k);
        repeat (7) step();
        #2;
        check("restart_ready_before", 64'(raw_pixel_ready), 64'd1);
        step();
        dpdmahstart = 1'b1;
        hact        = 16'd32;
        sz          = src_q.size();
        #2;
        check("restart_ready_blocked", 64'(raw_pixel_ready), 64'd0);
        step();
        check("restart_word_not_taken", 64'(src_q.size()), 64'(sz));
        exp_q.delete();
        push_line(32);
        line_beats    = 0;
        take_cyc      = -10;
        first_pending = 1'b1;
        #1;
        check("restart_valid_dropped", 64'(dp_pixel_valid), 64'd0);
        wait_drain(100);
        repeat (3) step();
        check("restart_words_left", 64'(src_q.size()), 64'(sz - 2));

        // Asynchronous reset in the middle of a line.
        fill_src(6);
        start_line(64);
        wait_beats(3, 50);
        step();
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset_dp_valid", 64'(dp_pixel_valid), 64'd0);
        check("midreset_dp_data", 64'(dp_pixel_data), 64'd0);
        check("midreset_raw_ready", 64'(raw_pixel_ready), 64'd0);
        exp_q.delete();
        first_pending = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        sz = src_q.size();
        line_beats = 0;
        repeat (20) step();
        check("postreset_no_take", 64'(src_q.size()), 64'(sz));
        check("postreset_no_beats", 64'(line_beats), 64'd0);

        // Recovery line after reset.
        start_line(16);
        wait_drain(60);
        repeat (3) step();
        check("recover_beats", 64'(line_beats), 64'd8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dport_pxunpack.md
DPORT_PXUNPACK -- requirements
Module: dport_pxunpack

Interface
REQ-001 Parameter FGCOL, default 24'h000000, is the RGB value for a set (1) Blit pixel.
REQ-002 Parameter BGCOL, default 24'hFFFFFF, is the RGB value for a clear (0) Blit pixel.
REQ-003 dpclk  in  1  single clock of the block; all logic on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 dpdmahstart  in  1  one-cycle line-start pulse.
REQ-006 hact  in  16  active pixels per line, sampled on dpdmahstart.
REQ-007 raw_pixel_valid  in  1  upstream FIFO word available.
REQ-008 raw_pixel_data  in  16  16 monochrome pixels, bit 15 leftmost.
REQ-009 raw_pixel_ready  out  1  word consumed this cycle when high with valid.
REQ-010 dp_pixel_valid  out  1  output beat available.
REQ-011 dp_pixel_data  out  48  two RGB pixels; left pixel [47:24], right pixel [23:0].
REQ-012 dp_pixel_ready  in  1  downstream stuffer accepts beat.

Function
REQ-013 States: IDLE (after reset), ACTIVE, DONE.
REQ-014 dpdmahstart in any state: next state ACTIVE, word buffer emptied, pair index 0, pixel count 0, dp_pixel_valid 0, hact latched; hact=0 goes to DONE instead.
REQ-015 In IDLE and DONE raw_pixel_ready is 0 and no beats are produced.
REQ-016 In the cycle dpdmahstart is high raw_pixel_ready is 0 (line start wins over a handshake).
REQ-017 Word buffer holds one word and a 3-bit pair index; pair k emits bits 15-2k (left) and 14-2k (right).
REQ-018 Output register loads the next pair when dp_pixel_valid is 0 or dp_pixel_ready is 1.
REQ-019 raw_pixel_ready is 1 in ACTIVE when the buffer is empty, or when pair 7 loads into the output register that cycle (no bubble between words).
REQ-020 Latency: word accepted in cycle N gives pair 0 valid in cycle N+1; sustained throughput is one beat per cycle with both handshakes continuously asserted.
REQ-021 dp_pixel_valid/data are held stable while valid=1 and ready=0.
REQ-022 Pixel count increments by 2 per loaded beat (16-bit, compare against latched hact).
REQ-023 On the beat that reaches or passes hact, the state goes to DONE and the remaining buffered word is discarded.
REQ-024 Odd hact: the final beat's right pixel is BGCOL regardless of the data bit.
REQ-025 Upstream empty mid-line: dp_pixel_valid drops to 0 without error; the line resumes when data arrives.
REQ-026 The beat in the output register when DONE is entered is still delivered normally.

Reset
REQ-027 While reset_n=0: state IDLE, raw_pixel_ready 0, dp_pixel_valid 0, dp_pixel_data 0, buffer empty, counters 0.
REQ-028 Reset deassertion takes effect on the first dpclk edge after release; no beat is emitted before a dpdmahstart.

Structure
REQ-029 The state encoding and the 48-bit beat width constant belong in the shared dport package with the attr field definitions.
REQ-030 The block is a single module; no sub-module.

Verification
REQ-031 hact=16, word 16'hA5A5, ready always 1 -> 8 beats from N+1: {FG,BG},{FG,BG},{BG,FG},{BG,FG},{FG,BG},{FG,BG},{BG,FG},{BG,FG}; then DONE, ready low.
REQ-032 hact=1280, FIFO always valid, dp_pixel_ready always 1 -> 640 consecutive beats with no bubble; 80 words consumed.
REQ-033 dp_pixel_ready toggled pseudo-randomly -> data held while stalled; pixel sequence matches a reference model exactly.
REQ-034 hact=3, word 16'hFFFF -> two beats {FG,FG},{FG,BG}; rest of word discarded, raw_pixel_ready 0.
REQ-035 dpdmahstart in the same cycle as raw valid&ready mid-line -> that word is not consumed, dp_pixel_valid 0 next cycle, the new line starts at pair 0 of the next word.
REQ-036 reset_n pulsed low mid-line -> outputs 0 immediately (asynchronous); after release no beats until dpdmahstart.
